// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad and delivers a debounced key code.
// Latency: press-to-button_pressed is at most (DEBOUNCE_FRAMES+1)*4*COL_DWELL+3 cycles.
// Backpressure: none; the outputs are levels plus a one-cycle strobe, and the consumer samples them freely.
//
// Ports:
//   clk            master clock (single domain)
//   rst_n          synchronous active-low reset
//   row[3:0]       keypad rows, active-low, asynchronous to clk (pulled up)
//   col[3:0]       keypad columns, active-low one-hot, registered
//   dec[3:0]       hex code of the accepted key; keeps the last key after release
//   button_pressed high while an accepted key is held
//   key_strobe     one-cycle pulse on the cycle button_pressed rises

module keypad_scanner #(
  parameter int COL_DWELL       = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] dec,
  output logic       button_pressed,
  output logic       key_strobe
);

  // Counter widths. The debounce counter must be able to hold DEBOUNCE_FRAMES itself.
  localparam int DW = (COL_DWELL > 1) ? $clog2(COL_DWELL) : 1;
  localparam int CW = (DEBOUNCE_FRAMES > 0) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL - 1);
  localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE_FRAMES);

  // Five-bit key value: bit 4 set means "no key".
  localparam logic [4:0] KEY_NONE = 5'h10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_GAP
  } state_t;

  // Map a flat intersection index (col*4 + row) onto the printed keypad legend.
  function automatic logic [3:0] key_of(input logic [3:0] idx);
    logic [3:0] k;
    case (idx)
      4'd0:    k = 4'h1;
      4'd1:    k = 4'h4;
      4'd2:    k = 4'h7;
      4'd3:    k = 4'h0;
      4'd4:    k = 4'h2;
      4'd5:    k = 4'h5;
      4'd6:    k = 4'h8;
      4'd7:    k = 4'hF;
      4'd8:    k = 4'h3;
      4'd9:    k = 4'h6;
      4'd10:   k = 4'h9;
      4'd11:   k = 4'hE;
      4'd12:   k = 4'hA;
      4'd13:   k = 4'hB;
      4'd14:   k = 4'hC;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    samp_c0;
  logic [3:0]    samp_c1;
  logic [3:0]    samp_c2;
  logic [4:0]    cand;
  logic [CW-1:0] db_cnt;
  logic [4:0]    acc;
  state_t        state;

  // ---------------------------------------------------------------------------
  // Frame evaluation
  // ---------------------------------------------------------------------------
  logic          dwell_last;
  logic          frame_done;
  logic [15:0]   hits;
  logic          hit_found;
  logic          hit_multi;
  logic [3:0]    hit_key;
  logic [4:0]    frame_key;

  assign dwell_last = (dwell_cnt == DWELL_LAST);
  assign frame_done = dwell_last && (col_idx == 2'd3);

  // Column 3 is never stored: its sample is the live synchronized row on the
  // same cycle the frame is resolved. Bit index is col*4 + row.
  assign hits = ~{row_sync, samp_c2, samp_c1, samp_c0};

  always_comb begin
    hit_found = 1'b0;
    hit_multi = 1'b0;
    hit_key   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (hits[i]) begin
        if (hit_found) begin
          hit_multi = 1'b1;
        end
        hit_found = 1'b1;
        hit_key   = key_of(4'(i));
      end
    end
  end

  // Ghosting or genuine multi-key both resolve to "no key".
  assign frame_key = (hit_found && !hit_multi) ? {1'b0, hit_key} : KEY_NONE;

  // ---------------------------------------------------------------------------
  // Debounce next-state
  // ---------------------------------------------------------------------------
  logic [4:0]    cand_nxt;
  logic [CW-1:0] db_cnt_nxt;
  logic          accept;

  always_comb begin
    cand_nxt   = cand;
    db_cnt_nxt = db_cnt;
    if (frame_key == cand) begin
      if (db_cnt != DB_MAX) begin
        db_cnt_nxt = db_cnt + 1'b1;
      end
    end else begin
      cand_nxt   = frame_key;
      db_cnt_nxt = CW'(1);
    end
  end

  // Acceptance looks at the post-update candidate, so the frame that completes
  // the run is the frame that is accepted.
  assign accept = frame_done && (db_cnt_nxt == DB_MAX) && (cand_nxt != acc);

  // ---------------------------------------------------------------------------
  // Sequential logic: synchronizer, scan, debounce and output FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta       <= 4'hF;
      row_sync       <= 4'hF;
      dwell_cnt      <= '0;
      col_idx        <= 2'd0;
      col            <= 4'b1110;
      samp_c0        <= 4'hF;
      samp_c1        <= 4'hF;
      samp_c2        <= 4'hF;
      cand           <= KEY_NONE;
      db_cnt         <= '0;
      acc            <= KEY_NONE;
      state          <= S_IDLE;
      dec            <= 4'h0;
      button_pressed <= 1'b0;
      key_strobe     <= 1'b0;
    end else begin
      row_meta   <= row;
      row_sync   <= row_meta;
      key_strobe <= 1'b0;

      // Scan: sample the active column at the end of its dwell, then move on.
      if (dwell_last) begin
        dwell_cnt <= '0;
        case (col_idx)
          2'd0:    samp_c0 <= row_sync;
          2'd1:    samp_c1 <= row_sync;
          2'd2:    samp_c2 <= row_sync;
          default: ;
        endcase
        col_idx <= col_idx + 2'd1;
        col     <= ~(4'b0001 << (col_idx + 2'd1));
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end

      if (frame_done) begin
        cand   <= cand_nxt;
        db_cnt <= db_cnt_nxt;
        if (accept) begin
          acc <= cand_nxt;
        end
      end

      // Output FSM. Accepts arrive at most once per frame, so GAP always
      // completes before another accept can be seen.
      case (state)
        S_IDLE: begin
          if (accept && !cand_nxt[4]) begin
            state          <= S_HELD;
            dec            <= cand_nxt[3:0];
            button_pressed <= 1'b1;
            key_strobe     <= 1'b1;
          end
        end
        S_HELD: begin
          if (accept) begin
            button_pressed <= 1'b0;
            if (cand_nxt[4]) begin
              state <= S_IDLE;
            end else begin
              // dec is loaded while button_pressed is low, so the consumer
              // never sees the code change under a held level.
              state <= S_GAP;
              dec   <= cand_nxt[3:0];
            end
          end
        end
        S_GAP: begin
          state          <= S_HELD;
          button_pressed <= 1'b1;
          key_strobe     <= 1'b1;
        end
        default: begin
          state          <= S_IDLE;
          button_pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] dec;
  logic       button_pressed;
  logic       key_strobe;

  keypad_scanner #(.COL_DWELL(8), .DEBOUNCE_FRAMES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row(row),
    .col(col),
    .dec(dec),
    .button_pressed(button_pressed),
    .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Keypad model: pressed[c*4+r] shorts column c to row r.
  logic [15:0] pressed = '0;
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !col[c]) row[r] = 1'b0;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: expected key codes pushed when a press is driven, popped on key_strobe.
  logic [3:0] exp_q[$];
  int n_strobe = 0;
  int n_fall   = 0;
  logic       prev_bp  = 1'b0;
  logic [3:0] prev_dec = 4'h0;

  always @(negedge clk) begin
    if (key_strobe) begin
      n_strobe++;
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("strobe_dec", dec, exp_q.pop_front());
    end
    if (key_strobe || (button_pressed && !prev_bp))
      check("strobe_vs_rise", key_strobe, button_pressed && !prev_bp);
    if (prev_bp && button_pressed && dec != prev_dec)
      check("dec_stable", dec, prev_dec);
    if (prev_bp && !button_pressed) n_fall++;
    prev_bp  = button_pressed;
    prev_dec = dec;
  end

  task automatic wait_bp(input logic lvl, input int maxc, output int n);
    n = 0;
    while (button_pressed !== lvl && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic int idx(input int c, input int r);
    return c * 4 + r;
  endfunction

  typedef struct {
    int         c;
    int         r;
    logic [3:0] key;
  } vec_t;

  initial begin
    vec_t       vecs[6];
    logic [3:0] scan_exp[5];
    int         n;
    int         s0;
    int         f0;

    vecs[0] = '{1, 1, 4'h5};
    vecs[1] = '{0, 0, 4'h1};
    vecs[2] = '{2, 3, 4'hE};
    vecs[3] = '{3, 3, 4'hD};
    vecs[4] = '{1, 3, 4'hF};
    vecs[5] = '{0, 3, 4'h0};
    scan_exp[0] = 4'b1110;
    scan_exp[1] = 4'b1101;
    scan_exp[2] = 4'b1011;
    scan_exp[3] = 4'b0111;
    scan_exp[4] = 4'b1110;

    // Reset and idle scan
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_dec", dec, 4'h0);
    check("rst_bp", button_pressed, 1'b0);
    check("rst_strobe", key_strobe, 1'b0);
    rst_n = 1'b1;
    s0 = n_strobe;
    for (int s = 1; s < 5; s++) begin
      repeat (8) @(posedge clk);
      #1 check("scan_col", col, scan_exp[s]);
    end
    repeat (64) @(negedge clk);
    check("idle_no_strobe", n_strobe - s0, 0);

    // Table-driven single presses
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      s0 = n_strobe;
      exp_q.push_back(vecs[v].key);
      pressed = '0;
      pressed[idx(vecs[v].c, vecs[v].r)] = 1'b1;
      wait_bp(1'b1, 99, n);
      check("press_lat", button_pressed, 1'b1);
      check("press_dec", dec, vecs[v].key);
      repeat (200 - n) @(negedge clk);
      check("press_one_strobe", n_strobe - s0, 1);
      pressed = '0;
      wait_bp(1'b0, 99, n);
      check("release_lat", button_pressed, 1'b0);
      check("release_dec_hold", dec, vecs[v].key);
      repeat (10) @(negedge clk);
    end

    // Bounce on key 9
    s0 = n_strobe;
    f0 = n_fall;
    exp_q.push_back(4'h9);
    for (int t = 0; t < 32; t++) begin
      if (t % 3 == 0) pressed[idx(2, 2)] = ~pressed[idx(2, 2)];
      @(negedge clk);
    end
    pressed[idx(2, 2)] = 1'b1;
    wait_bp(1'b1, 130, n);
    check("bounce_accept", button_pressed, 1'b1);
    repeat (100) @(negedge clk);
    check("bounce_one_strobe", n_strobe - s0, 1);
    check("bounce_no_fall", n_fall - f0, 0);
    check("bounce_dec", dec, 4'h9);
    pressed = '0;
    wait_bp(1'b0, 99, n);
    check("bounce_release", button_pressed, 1'b0);
    repeat (10) @(negedge clk);

    // Key-to-key: A then directly B
    exp_q.push_back(4'hA);
    pressed = '0;
    pressed[idx(3, 0)] = 1'b1;
    wait_bp(1'b1, 99, n);
    check("k2k_a_accept", button_pressed, 1'b1);
    repeat (20) @(negedge clk);
    s0 = n_strobe;
    exp_q.push_back(4'hB);
    pressed = '0;
    pressed[idx(3, 1)] = 1'b1;
    wait_bp(1'b0, 99, n);
    check("k2k_gap_seen", button_pressed, 1'b0);
    check("k2k_gap_dec", dec, 4'hB);
    @(negedge clk);
    check("k2k_gap_1cyc", button_pressed, 1'b1);
    check("k2k_strobe", key_strobe, 1'b1);
    check("k2k_dec", dec, 4'hB);
    repeat (20) @(negedge clk);
    check("k2k_one_strobe", n_strobe - s0, 1);
    pressed = '0;
    wait_bp(1'b0, 99, n);
    check("k2k_release", button_pressed, 1'b0);
    repeat (10) @(negedge clk);

    // Multi-key: 1 and D together
    s0 = n_strobe;
    pressed = '0;
    pressed[idx(0, 0)] = 1'b1;
    pressed[idx(3, 3)] = 1'b1;
    repeat (150) @(negedge clk);
    check("multi_no_press", button_pressed, 1'b0);
    check("multi_no_strobe", n_strobe - s0, 0);
    exp_q.push_back(4'h1);
    pressed[idx(3, 3)] = 1'b0;
    wait_bp(1'b1, 99, n);
    check("multi_then_1", button_pressed, 1'b1);
    check("multi_then_1_dec", dec, 4'h1);
    pressed = '0;
    wait_bp(1'b0, 99, n);
    check("multi_release", button_pressed, 1'b0);
    repeat (10) @(negedge clk);

    // Reset while 7 is held and accepted
    exp_q.push_back(4'h7);
    pressed[idx(0, 2)] = 1'b1;
    wait_bp(1'b1, 99, n);
    check("rstmid_accept", button_pressed, 1'b1);
    check("rstmid_dec7", dec, 4'h7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_col", col, 4'b1110);
    check("rstmid_dec", dec, 4'h0);
    check("rstmid_bp", button_pressed, 1'b0);
    check("rstmid_strobe", key_strobe, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'h7);
    wait_bp(1'b1, 140, n);
    check("rstmid_reaccept", button_pressed, 1'b1);
    check("rstmid_two_frames", n >= 64, 1);
    check("rstmid_dec_again", dec, 4'h7);
    pressed = '0;
    wait_bp(1'b0, 99, n);
    repeat (5) @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
